solver_feeder: RTL

//   Host-side driver for one solver instance. Takes a job as a stream of
//   c_re/c_im limbs and replays it onto the solver's limb-write port. Then

---
 rtl/solver_feeder_if.sv | 36 +++
 rtl/solver_feeder.sv | 111 +++++++++++
 2 files changed

// File: rtl/solver_feeder_if.sv
// solver_feeder_if: job, limb-write, solver-status and result signals of one solver feeder
// Ports (master = feeder side):
//   job_valid/job_ready/job_data     host limb stream into the feeder
//   wr_en/wr_sel/wr_limb/wr_data     limb writes toward the solver
//   solver_ready/solver_iter         solver completion level and iteration count
//   res_valid/res_ready/res_*        result handshake back to the host
//   busy                             a job is partially loaded or in flight
interface solver_feeder_if #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS  = 27
);
    logic                       job_valid;
    logic                       job_ready;
    logic [LIMB_SIZE_BITS-1:0]  job_data;
    logic                       wr_en;
    logic                       wr_sel;
    logic [LIMB_INDEX_BITS-1:0] wr_limb;
    logic [LIMB_SIZE_BITS-1:0]  wr_data;
    logic                       solver_ready;
    logic [LIMB_SIZE_BITS-1:0]  solver_iter;
    logic                       res_valid;
    logic                       res_ready;
    logic [LIMB_SIZE_BITS-1:0]  res_iterations;
    logic                       res_timeout;
    logic                       busy;
    modport master (
        input  job_valid, job_data, solver_ready, solver_iter, res_ready,
        output job_ready, wr_en, wr_sel, wr_limb, wr_data,
               res_valid, res_iterations, res_timeout, busy
    );
    modport slave (
        output job_valid, job_data, solver_ready, solver_iter, res_ready,
        input  job_ready, wr_en, wr_sel, wr_limb, wr_data,
               res_valid, res_iterations, res_timeout, busy
    );
endinterface

// File: rtl/solver_feeder.sv
// solver_feeder: replays a c_re/c_im limb job onto a solver and returns its iteration count or a timeout
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   bus (master)   job stream in, limb writes out, solver status in, result handshake out, busy
module solver_feeder #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS  = 27,
    parameter int NUM_LIMBS       = 4,
    parameter int TIMEOUT_BITS    = 32,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input logic              clock,
    input logic              reset,
    solver_feeder_if.master  bus
);
    typedef enum logic [1:0] {S_LOAD, S_WAIT, S_RESULT} state_t;
    state_t                     state, state_n;
    logic [LIMB_INDEX_BITS-1:0] cnt, cnt_n, wr_limb_n;
    logic [TIMEOUT_BITS-1:0]    wcnt, wcnt_n;
    logic [LIMB_SIZE_BITS-1:0]  wr_data_n, res_iterations_n;
    logic sel, sel_n, armed, armed_n;
    logic wr_en_n, wr_sel_n, res_valid_n, res_timeout_n, busy_n;
    logic accept, last, done, expired;
    assign bus.job_ready = (state == S_LOAD) & ~reset;
    assign accept  = bus.job_valid & (state == S_LOAD);
    assign last    = cnt == LIMB_INDEX_BITS'(NUM_LIMBS - 1);
    // out_ready may still be high from the previous job; only trust it once seen low
    assign done    = armed & bus.solver_ready;
    assign expired = (TIMEOUT_CYCLES != 0) && (wcnt == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));
    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        sel_n            = sel;
        armed_n          = armed;
        wcnt_n           = wcnt;
        wr_en_n          = 1'b0;
        wr_sel_n         = bus.wr_sel;
        wr_limb_n        = bus.wr_limb;
        wr_data_n        = bus.wr_data;
        res_valid_n      = bus.res_valid;
        res_iterations_n = bus.res_iterations;
        res_timeout_n    = bus.res_timeout;
        case (state)
            S_LOAD: if (accept) begin
                wr_en_n   = 1'b1;
                wr_sel_n  = sel;
                wr_limb_n = cnt;
                wr_data_n = bus.job_data;
                cnt_n     = last ? '0 : cnt + 1'b1;
                sel_n     = last ? ~sel : sel;
                state_n   = (last & sel) ? S_WAIT : S_LOAD;
            end
            S_WAIT: begin
                armed_n = armed | ~bus.solver_ready;
                if (done) begin
                    res_iterations_n = bus.solver_iter;
                    res_timeout_n    = 1'b0;
                    res_valid_n      = 1'b1;
                    state_n          = S_RESULT;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                    if (expired) begin
                        res_iterations_n = '0;
                        res_timeout_n    = 1'b1;
                        res_valid_n      = 1'b1;
                        state_n          = S_RESULT;
                    end
                end
            end
            S_RESULT: if (bus.res_ready) begin
                res_valid_n = 1'b0;
                armed_n     = 1'b0;
                wcnt_n      = '0;
                state_n     = S_LOAD;
            end
            default: state_n = S_LOAD;
        endcase
        busy_n = (state_n != S_LOAD) | (cnt_n != '0) | sel_n;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= S_LOAD;
            cnt                <= '0;
            sel                <= 1'b0;
            armed              <= 1'b0;
            wcnt               <= '0;
            bus.wr_en          <= 1'b0;
            bus.wr_sel         <= 1'b0;
            bus.wr_limb        <= '0;
            bus.wr_data        <= '0;
            bus.res_valid      <= 1'b0;
            bus.res_iterations <= '0;
            bus.res_timeout    <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            sel                <= sel_n;
            armed              <= armed_n;
            wcnt               <= wcnt_n;
            bus.wr_en          <= wr_en_n;
            bus.wr_sel         <= wr_sel_n;
            bus.wr_limb        <= wr_limb_n;
            bus.wr_data        <= wr_data_n;
            bus.res_valid      <= res_valid_n;
            bus.res_iterations <= res_iterations_n;
            bus.res_timeout    <= res_timeout_n;
            bus.busy           <= busy_n;
        end
    end
endmodule
